// File: rtl/jt900h_dump_rd.sv
`default_nettype none
// ============================================================================
// Module   : jt900h_dump_rd
// Purpose  : Reader side of the CPU register dump port. On a start pulse it
//            walks dump addresses 0x00..LAST_ADDR, captures each byte from
//            the register file and streams it out over a valid/ready byte
//            interface. The frame is a header byte, then the data bytes, then
//            a checksum byte chosen so that data + checksum sum to 0 mod 256.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   rst        in   1  asynchronous reset, active high
//   clk        in   1  system clock (no clock enable used)
//   start      in   1  one-cycle frame request, ignored while busy
//   busy       out  1  frame in progress
//   halt       out  1  copy of busy when HALT_EN=1, else 0
//   dmp_addr   out  8  dump address to the register file
//   dmp_din    in   8  dump data, valid one clk after dmp_addr changes
//   out_data   out  8  stream byte
//   out_valid  out  1  stream byte valid
//   out_ready  in   1  consumer ready
//   done       out  1  one-cycle pulse after the checksum is accepted
// ============================================================================
module jt900h_dump_rd #(
  parameter logic [7:0] LAST_ADDR = 8'h51,
  parameter logic [7:0] HDR_BYTE  = 8'hA5,
  parameter bit         HALT_EN   = 1'b1
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       start,
  output logic       busy,
  output logic       halt,
  output logic [7:0] dmp_addr,
  input  logic [7:0] dmp_din,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_CAPT   = 3'd3,
    ST_SEND   = 3'd4,
    ST_CSUM   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q,  addr_d;
  logic [7:0] data_q,  data_d;
  logic [7:0] acc_q,   acc_d;
  logic       done_q,  done_d;
  logic       w_hs;

  // A handshake only counts in the states that present a byte.
  assign out_valid = (state_q == ST_HDR) || (state_q == ST_SEND) ||
                     (state_q == ST_CSUM);
  assign w_hs      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      acc_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          addr_d  = 8'h00;
          acc_d   = 8'h00;
          // The header is loaded here so it is already stable when valid rises.
          data_d  = HDR_BYTE;
        end
      end
      ST_HDR: begin
        if (w_hs) state_d = ST_RDWAIT;
      end
      // The register file registers dmp_din, so one dead cycle is needed
      // after every address change before the data can be captured.
      ST_RDWAIT: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        data_d  = dmp_din;
        acc_d   = acc_q + dmp_din;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_CSUM;
            data_d  = ~acc_q + 8'd1;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = ST_RDWAIT;
          end
        end
      end
      ST_CSUM: begin
        if (w_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign dmp_addr = addr_q;
  assign out_data = data_q;
  assign done     = done_q;

  generate
    if (HALT_EN) begin : g_halt_on
      assign halt = busy;
    end else begin : g_halt_off
      assign halt = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_jt900h_dump_rd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_jt900h_dump_rd
// Purpose  : Self-checking bench for jt900h_dump_rd. A register-file model
//            answers dump reads; expected frames are queued when a start is
//            issued and compared byte by byte on each stream handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt900h_dump_rd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, halt, out_valid, done;
  logic [7:0] dmp_addr, out_data;
  logic [7:0] dmp_din = 8'h00;

  // HALT_EN=0 instance, shares the stimulus of the main one
  logic       busy_nh, halt_nh, valid_nh, done_nh;
  logic [7:0] addr_nh, data_nh;
  logic [7:0] din_nh = 8'h00;

  // LAST_ADDR=0 instance with its own start, ready tied high
  logic       start_l0 = 1'b0;
  logic       busy_l0, halt_l0, valid_l0, done_l0;
  logic [7:0] addr_l0, data_l0;
  logic [7:0] din_l0 = 8'h00;

  always #5 clk = ~clk;

  jt900h_dump_rd u_dut (
    .rst(rst), .clk(clk), .start(start), .busy(busy), .halt(halt),
    .dmp_addr(dmp_addr), .dmp_din(dmp_din), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  jt900h_dump_rd #(.HALT_EN(1'b0)) u_dut_nh (
    .rst(rst), .clk(clk), .start(start), .busy(busy_nh), .halt(halt_nh),
    .dmp_addr(addr_nh), .dmp_din(din_nh), .out_data(data_nh),
    .out_valid(valid_nh), .out_ready(out_ready), .done(done_nh)
  );

  jt900h_dump_rd #(.LAST_ADDR(8'h00)) u_dut_l0 (
    .rst(rst), .clk(clk), .start(start_l0), .busy(busy_l0), .halt(halt_l0),
    .dmp_addr(addr_l0), .dmp_din(din_l0), .out_data(data_l0),
    .out_valid(valid_l0), .out_ready(1'b1), .done(done_l0)
  );

  // Register-file model: data registered one clk after the address.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    dmp_din <= mem[dmp_addr];
    din_nh  <= mem[addr_nh];
    din_l0  <= mem[addr_l0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard and monitor state
  logic [7:0] exp_q[$];
  int         hs_cyc[$];
  logic [7:0] l0_q[$];
  int         last_hs_cyc = 0;
  int         frame_idx   = 0;
  logic [7:0] frame_sum   = 8'h00;
  int         busy_cnt    = 0;
  int         done_cnt    = 0;
  int         done_l0_cnt = 0;
  int         halt_err    = 0;
  int         halt0_err   = 0;
  bit         nh_busy_seen = 1'b0;
  int         start_cyc   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (halt !== busy) halt_err++;
      if (halt_nh !== 1'b0) halt0_err++;
      if (busy_nh) nh_busy_seen = 1'b1;
      if (done) begin
        done_cnt++;
        check("done_after_csum", cyc - last_hs_cyc, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("stream_byte", out_data, exp_q.pop_front());
        if (frame_idx > 0) frame_sum = frame_sum + out_data;
        frame_idx++;
        hs_cyc.push_back(cyc);
        last_hs_cyc = cyc;
      end
      if (valid_l0) l0_q.push_back(data_l0);
      if (done_l0) done_l0_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    logic [7:0] s;
    s = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i <= 8'h51; i++) begin
      exp_q.push_back(mem[i]);
      s = s + mem[i];
    end
    exp_q.push_back(8'h00 - s);
  endtask

  task automatic pulse_start();
    frame_idx = 0;
    frame_sum = 8'h00;
    busy_cnt  = 0;
    hs_cyc.delete();
    push_frame();
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_addr(input logic [7:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dmp_addr == a && out_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("wait_addr_timeout", ok, 1);
  endtask

  // Waits for busy to fall, then one more cycle so the done pulse is seen,
  // and checks the frame-level properties.
  task automatic finish_frame(input string tag, input int exp_busy);
    bit ok;
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!busy) begin ok = 1'b1; break; end
    end
    tick();
    check({tag, "_finished"}, ok, 1);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_sum_zero"}, frame_sum, 0);
    if (exp_busy > 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_halt_eq_busy"}, halt_err, 0);
  endtask

  typedef struct {
    logic [7:0] fill;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] csum;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{8'h00, 8'h12, 8'h34, 8'hBA};
    vecs[1] = '{8'h01, 8'h00, 8'h00, 8'hB0};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'h50};
    vecs[3] = '{8'h02, 8'h01, 8'h00, 8'h5F};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", dmp_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_halt", halt, 0);
    rst = 1'b0;
    tick();

    // Header and first bytes, with latency checks
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    pulse_start();
    finish_frame("first", 248);
    check("byte_count", hs_cyc.size(), 84);
    check("hdr_latency", hs_cyc[0] - start_cyc, 1);
    check("gap_b0", hs_cyc[1] - hs_cyc[0], 3);
    check("gap_b1", hs_cyc[2] - hs_cyc[1], 3);

    // Constant-fill frames with known checksums
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 8'h50; i++) mem[i] = vecs[v].fill;
      mem[8'h50] = vecs[v].hi;
      mem[8'h51] = vecs[v].lo;
      pulse_start();
      finish_frame("table", 248);
      check("table_csum", out_data, vecs[v].csum);
      check("table_bytes", hs_cyc.size(), 84);
    end

    // Backpressure on the byte for address 0x40
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h40] = 8'h77;
    mem[8'h41] = 8'h5A;
    pulse_start();
    wait_addr(8'h40);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data", out_data, 8'h77);
      check("bp_addr", dmp_addr, 8'h40);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    finish_frame("bp", 0);

    // Start while busy is ignored
    pulse_start();
    wait_addr(8'h10);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame("sbusy", 248);
    for (int i = 0; i < 4; i++) tick();
    check("sbusy_no_restart", busy, 0);

    // Reset mid-frame
    pulse_start();
    wait_addr(8'h20);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_addr", dmp_addr, 0);
    check("mrst_data", out_data, 0);
    check("mrst_halt", halt, 0);
    exp_q.delete();
    begin
      int d0;
      d0 = done_cnt;
      tick(); tick();
      check("mrst_no_done", done_cnt - d0, 0);
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    pulse_start();
    finish_frame("after_rst", 248);
    check("after_rst_bytes", hs_cyc.size(), 84);

    // HALT_EN=0 instance ran alongside without raising halt
    check("nohalt_ran", nh_busy_seen, 1);
    check("nohalt_halt_low", halt0_err, 0);

    // LAST_ADDR=0: a single data byte per frame
    mem[0] = 8'h3C;
    l0_q.delete();
    start_l0 = 1'b1;
    tick();
    start_l0 = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("l0_bytes", l0_q.size(), 3);
    if (l0_q.size() == 3) begin
      check("l0_hdr", l0_q[0], 8'hA5);
      check("l0_data", l0_q[1], 8'h3C);
      check("l0_csum", l0_q[2], 8'hC4);
    end
    check("l0_done", done_l0_cnt, 1);
    check("l0_idle", busy_l0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
